// File: rtl/lr_sum_acc.sv
// ============================================================================
// Module   : lr_sum_acc
// Brief    : Streaming accumulator of sum(x), sum(y), sum(x*x) and sum(x*y)
//            for a linear-regression solver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_sum_acc #(
    parameter int N_SAMPLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic [23:0] sum_x,
    output logic [23:0] sum_y,
    output logic [39:0] sum_xx,
    output logic [39:0] sum_xy,
    output logic [8:0]  count,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] N_LAST = 9'(N_SAMPLES);

    state_t      state;
    logic [8:0]  accepted;
    logic        s1_valid;
    logic [15:0] s1_x;
    logic [15:0] s1_y;
    logic        s2_valid;
    logic [15:0] s2_x;
    logic [15:0] s2_y;
    logic [31:0] s2_xx;
    logic [31:0] s2_xy;

    logic        accept;
    logic [8:0]  accepted_next;
    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] prod_xx;
    logic [31:0] prod_xy;

    // A sample coinciding with START is dropped: the run it would belong to is being discarded.
    assign accept        = in_valid && in_ready && !start && (state == ACCUM);
    assign accepted_next = accepted + 9'd1;
    assign x_ext         = {{16{s1_x[15]}}, s1_x};
    assign y_ext         = {{16{s1_y[15]}}, s1_y};
    assign prod_xx       = x_ext * x_ext;
    assign prod_xy       = x_ext * y_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            accepted  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s2_valid  <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
            s2_xx     <= '0;
            s2_xy     <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            sum_xx    <= '0;
            sum_xy    <= '0;
            count     <= '0;
        end else if (start) begin
            state     <= ACCUM;
            accepted  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            sum_x     <= '0;
            sum_y     <= '0;
            sum_xx    <= '0;
            sum_xy    <= '0;
            count     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_x <= x_in;
                s1_y <= y_in;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x  <= s1_x;
                s2_y  <= s1_y;
                s2_xx <= prod_xx;
                s2_xy <= prod_xy;
            end

            if (s2_valid) begin
                sum_x  <= sum_x + {{8{s2_x[15]}}, s2_x};
                sum_y  <= sum_y + {{8{s2_y[15]}}, s2_y};
                sum_xx <= sum_xx + {{8{s2_xx[31]}}, s2_xx};
                sum_xy <= sum_xy + {{8{s2_xy[31]}}, s2_xy};
                count  <= count + 9'd1;
            end

            case (state)
                ACCUM: begin
                    if (accept) begin
                        accepted <= accepted_next;
                        if (accepted_next == N_LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                // Stage 1 empty means the final sample sits in stage 2 and lands this edge.
                DRAIN: begin
                    if (!s1_valid) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lr_sum_acc.sv
// ============================================================================
// Module   : tb_lr_sum_acc
// Brief    : Directed, table-driven bench for lr_sum_acc (N_SAMPLES=4 and 256).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lr_sum_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               start4, valid4, ready4, ov4, busy4;
    logic [15:0]        x4, y4;
    logic signed [23:0] sx4, sy4;
    logic signed [39:0] sxx4, sxy4;
    logic [8:0]         cnt4;

    logic               starta, valida, readya, ova, busya;
    logic [15:0]        xa, ya;
    logic signed [23:0] sxa, sya;
    logic signed [39:0] sxxa, sxya;
    logic [8:0]         cnta;

    lr_sum_acc #(.N_SAMPLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(valid4), .in_ready(ready4),
        .x_in(x4), .y_in(y4), .sum_x(sx4), .sum_y(sy4), .sum_xx(sxx4), .sum_xy(sxy4),
        .count(cnt4), .out_valid(ov4), .busy(busy4)
    );

    lr_sum_acc #(.N_SAMPLES(256)) u_dut256 (
        .clk(clk), .rst(rst), .start(starta), .in_valid(valida), .in_ready(readya),
        .x_in(xa), .y_in(ya), .sum_x(sxa), .sum_y(sya), .sum_xx(sxxa), .sum_xy(sxya),
        .count(cnta), .out_valid(ova), .busy(busya)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic s;
        logic v;
        int   x;
        int   y;
        logic e_rdy;
        logic e_ov;
        logic e_busy;
        int   e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic s, input logic v, input int x, input int y);
        start4 = s;
        valid4 = v;
        x4     = 16'(x);
        y4     = 16'(y);
        tick();
        start4 = 1'b0;
        valid4 = 1'b0;
    endtask

    task automatic drivea(input logic s, input logic v, input int x, input int y);
        starta = s;
        valida = v;
        xa     = 16'(x);
        ya     = 16'(y);
        tick();
        starta = 1'b0;
        valida = 1'b0;
    endtask

    task automatic chk_sums4(input string tag, input int ex, input int ey,
                             input int exx, input int exy, input int ec);
        chk({tag, "_sum_x"},  longint'(sx4),  ex);
        chk({tag, "_sum_y"},  longint'(sy4),  ey);
        chk({tag, "_sum_xx"}, longint'(sxx4), exx);
        chk({tag, "_sum_xy"}, longint'(sxy4), exy);
        chk({tag, "_count"},  longint'(cnt4), ec);
    endtask

    initial begin
        // Alternating-valid run: {start, valid, x, y, ready, out_valid, busy, count} after each edge
        tbl[0]  = '{1'b1, 1'b0,  0, 0, 1'b1, 1'b0, 1'b1, 0};
        tbl[1]  = '{1'b0, 1'b1, -1, 5, 1'b1, 1'b0, 1'b1, 0};
        tbl[2]  = '{1'b0, 1'b0,  0, 0, 1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 1'b1, -2, 5, 1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b0, 1'b0,  0, 0, 1'b1, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b1, -3, 5, 1'b1, 1'b0, 1'b1, 2};
        tbl[6]  = '{1'b0, 1'b0,  0, 0, 1'b1, 1'b0, 1'b1, 2};
        tbl[7]  = '{1'b0, 1'b1, -4, 5, 1'b0, 1'b0, 1'b1, 3};
        tbl[8]  = '{1'b0, 1'b1, -9, 9, 1'b0, 1'b0, 1'b1, 3};
        tbl[9]  = '{1'b0, 1'b1, -9, 9, 1'b0, 1'b1, 1'b0, 4};
        tbl[10] = '{1'b0, 1'b1, -9, 9, 1'b0, 1'b1, 1'b0, 4};

        rst = 1'b1;
        start4 = 1'b0; valid4 = 1'b0; x4 = '0; y4 = '0;
        starta = 1'b0; valida = 1'b0; xa = '0; ya = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", ready4, 0);
        chk("rst_ov",    ov4,    0);
        chk("rst_busy",  busy4,  0);
        chk_sums4("rst", 0, 0, 0, 0, 0);
        chk("rst_a_cnt", cnta, 0);

        // IDLE ignores samples without START
        drive4(1'b0, 1'b1, 3, 3);
        drive4(1'b0, 1'b1, 3, 3);
        chk("idle_busy",  busy4, 0);
        chk("idle_ready", ready4, 0);
        chk("idle_count", cnt4, 0);

        // Basic run x=1..4, y=2x with exact OUT_VALID latency
        drive4(1'b1, 1'b0, 0, 0);
        chk("basic_ready_after_start", ready4, 1);
        for (int i = 1; i <= 4; i++) drive4(1'b0, 1'b1, i, 2 * i);
        chk("basic_ready_after_last", ready4, 0);
        chk("basic_ov_e0", ov4, 0);
        chk("basic_busy_e0", busy4, 1);
        tick();
        chk("basic_ov_e1", ov4, 0);
        tick();
        chk("basic_ov_e2", ov4, 1);
        chk("basic_busy_e2", busy4, 0);
        chk_sums4("basic", 10, 20, 30, 60, 4);
        tick();
        chk("basic_ov_hold", ov4, 1);
        chk("basic_hold_sx", longint'(sx4), 10);

        // START in DONE with a same-edge sample
        drive4(1'b1, 1'b1, 7, 7);
        chk("redone_ov", ov4, 0);
        chk("redone_busy", busy4, 1);
        chk("redone_ready", ready4, 1);
        chk("redone_count", cnt4, 0);
        drive4(1'b0, 1'b0, 0, 0);
        tick();
        chk("redone_count_late", cnt4, 0);
        chk("redone_sx_late", longint'(sx4), 0);

        // Alternating IN_VALID with surplus pulses after the last accept
        for (int i = 0; i < 11; i++) begin
            drive4(tbl[i].s, tbl[i].v, tbl[i].x, tbl[i].y);
            chk($sformatf("tbl%0d_ready", i), ready4, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_ov",    i), ov4,    tbl[i].e_ov);
            chk($sformatf("tbl%0d_busy",  i), busy4,  tbl[i].e_busy);
            chk($sformatf("tbl%0d_count", i), cnt4,   tbl[i].e_cnt);
        end
        chk_sums4("alt", -10, 20, 30, -50, 4);

        // Restart with two samples in flight
        drive4(1'b1, 1'b0, 0, 0);
        drive4(1'b0, 1'b1, 5, 5);
        drive4(1'b0, 1'b1, 5, 5);
        drive4(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive4(1'b0, 1'b1, 1, 1);
        tick();
        tick();
        chk("restart_ov", ov4, 1);
        chk_sums4("restart", 4, 4, 4, 4, 4);

        // Reset during DRAIN
        drive4(1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) drive4(1'b0, 1'b1, i, 2 * i);
        chk("drain_busy", busy4, 1);
        chk("drain_ready", ready4, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("drainrst_ready", ready4, 0);
        chk("drainrst_ov", ov4, 0);
        chk("drainrst_busy", busy4, 0);
        chk_sums4("drainrst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drainrst_no_ov%0d", i), ov4, 0);
        end
        drive4(1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) drive4(1'b0, 1'b1, i, 2 * i);
        tick();
        tick();
        chk("after_rst_ov", ov4, 1);
        chk_sums4("after_rst", 10, 20, 30, 60, 4);

        // 256 samples at the most negative value
        drivea(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 256; i++) drivea(1'b0, 1'b1, -32768, -32768);
        chk("big_ready_after_last", readya, 0);
        begin
            int waited = 0;
            while (!ova && waited < 10) begin
                tick();
                waited++;
            end
            chk("big_ov_timeout", ova, 1);
        end
        chk("big_sum_x",  longint'(sxa),  -8388608);
        chk("big_sum_y",  longint'(sya),  -8388608);
        chk("big_sum_xx", longint'(sxxa), 64'sd274877906944);
        chk("big_sum_xy", longint'(sxya), 64'sd274877906944);
        chk("big_count",  cnta, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
